pc_sequencer: RTL and testbench

- Fetch/execute sequencer for the 16-bit single-cycle CPU core.
- Owns the program counter and fetches instructions over a req/ack instruction-memory handshake.
- Latches each instruction for the decoder and issues a one-cycle execute strobe that gates register-file and data-memory writes.
- Resolves the next PC from the decoder's branch-select, offset and halt outputs together with the ALU Z/N flags.

---
 rtl/pc_sequencer_if.sv | 23 ++
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Instruction-memory req/ack bus between pc_sequencer (master) and the fetch memory (slave).
interface pc_sequencer_if #(
   parameter int PC_W = 16
) ();
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [15:0]     imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer for the 16-bit single-cycle core: owns the PC, fetches over req/ack.
// Optional retired-instruction counter enabled by macro PC_SEQ_INSTRET_EN.
module pc_sequencer #(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
   input  logic                clk,
   input  logic                rst,
   pc_sequencer_if.master      imem,
   output logic [15:0]         inst,
   output logic                exec_en,
   input  logic [2:0]          BS,
   input  logic [5:0]          OFF,
   input  logic                HALT,
   input  logic                Z,
   input  logic                N,
   input  logic                run,
   output logic [PC_W-1:0]     pc,
   output logic                branch_taken,
   output logic                halted,
   output logic [31:0]         instret
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_EXEC   = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     inst_q, inst_d;
   logic            bt_q, bt_d;
   logic            take_s;
   logic [PC_W-1:0] off_ext_s;
   logic [PC_W-1:0] next_pc_s;

   always_comb begin
      take_s = 1'b0;
      case (BS)
         3'b000:  take_s = Z;
         3'b001:  take_s = ~Z;
         3'b010:  take_s = ~N;
         3'b011:  take_s = N;
         default: take_s = 1'b0;
      endcase
   end

   // Sum is naturally modulo 2^PC_W, so wrap at both ends of the address space needs no special case.
   assign off_ext_s = {{(PC_W-6){OFF[5]}}, OFF};
   assign next_pc_s = pc_q + {{(PC_W-1){1'b0}}, 1'b1} + (take_s ? off_ext_s : {PC_W{1'b0}});

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      bt_d    = bt_q;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem.imem_ack) begin
               inst_d  = imem.imem_rdata;
               state_d = ST_EXEC;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_EXEC: begin
            // HALT still advances the PC so that run resumes after the HALT word.
            pc_d = next_pc_s;
            bt_d = take_s;
            if (HALT) begin
               state_d = ST_HALTED;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_HALTED: begin
            if (run) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_HALTED;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         inst_q  <= 16'h0000;
         bt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         bt_q    <= bt_d;
      end
   end

   assign imem.imem_req  = (state_q == ST_FETCH);
   assign imem.imem_addr = pc_q;
   assign exec_en        = (state_q == ST_EXEC);
   assign halted         = (state_q == ST_HALTED);
   assign pc             = pc_q;
   assign inst           = inst_q;
   assign branch_taken   = bt_q;

`ifdef PC_SEQ_INSTRET_EN
   logic [31:0] instret_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instret_q <= 32'd0;
      end else if (state_q == ST_EXEC) begin
         instret_q <= instret_q + 32'd1;
      end else begin
         instret_q <= instret_q;
      end
   end

   assign instret = instret_q;
`else
   assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed steps plus random instructions against a PC model.
module tb_pc_sequencer;
   localparam int PC_W = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pc_sequencer_if #(.PC_W(PC_W)) imem_bus ();

   logic [15:0]     inst;
   logic            exec_en;
   logic [2:0]      bs;
   logic [5:0]      off;
   logic            hlt;
   logic            z;
   logic            n;
   logic            run;
   logic [PC_W-1:0] pc;
   logic            branch_taken;
   logic            halted;
   logic [31:0]     instret;

   pc_sequencer #(.PC_W(PC_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .imem         (imem_bus),
      .inst         (inst),
      .exec_en      (exec_en),
      .BS           (bs),
      .OFF          (off),
      .HALT         (hlt),
      .Z            (z),
      .N            (n),
      .run          (run),
      .pc           (pc),
      .branch_taken (branch_taken),
      .halted       (halted),
      .instret      (instret)
   );

   int          errors = 0;
   int          checks = 0;
   int          model_pc = 0;
   int unsigned model_instret = 0;
   bit          model_bt = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_take(input logic [2:0] b, input logic zz, input logic nn);
      case (b)
         3'd0:    return zz;
         3'd1:    return !zz;
         3'd2:    return !nn;
         3'd3:    return nn;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int ref_next(input int p, input bit t, input logic [5:0] o);
      int o_int;
      o_int = {26'd0, o};
      if (o[5]) o_int = o_int - 64;
      return (p + 1 + (t ? o_int : 0)) & 32'h0000FFFF;
   endfunction

   function automatic logic [31:0] exp_instret();
`ifdef PC_SEQ_INSTRET_EN
      return model_instret;
`else
      return 32'd0;
`endif
   endfunction

   task automatic scramble_decoder();
      bs  = 3'($urandom);
      off = 6'($urandom);
      hlt = 1'($urandom);
      z   = 1'($urandom);
      n   = 1'($urandom);
   endtask

   task automatic reset_seq(input int hold);
      rst = 1'b1;
      #1;
      model_pc = 0; model_bt = 1'b0; model_instret = 0;
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_req", 32'(imem_bus.imem_req), 32'd0);
      chk("rst_exec_en", 32'(exec_en), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_branch_taken", 32'(branch_taken), 32'd0);
      chk("rst_inst", 32'(inst), 32'd0);
      chk("rst_instret", instret, 32'd0);
      repeat (hold) begin
         @(negedge clk);
         chk("rst_hold_exec_en", 32'(exec_en), 32'd0);
         chk("rst_hold_req", 32'(imem_bus.imem_req), 32'd0);
      end
      rst = 1'b0;
      #1;
      chk("idle_req", 32'(imem_bus.imem_req), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("first_fetch_req", 32'(imem_bus.imem_req), 32'd1);
      chk("first_fetch_addr", 32'(imem_bus.imem_addr), 32'd0);
   endtask

   task automatic fetch(input int waits, output logic [15:0] word);
      chk("fetch_req", 32'(imem_bus.imem_req), 32'd1);
      chk("fetch_addr", 32'(imem_bus.imem_addr), 32'(model_pc));
      chk("fetch_exec_en", 32'(exec_en), 32'd0);
      for (int i = 0; i < waits; i++) begin
         imem_bus.imem_ack = 1'b0;
         @(posedge clk);
         @(negedge clk);
         chk("stall_req", 32'(imem_bus.imem_req), 32'd1);
         chk("stall_pc", 32'(pc), 32'(model_pc));
         chk("stall_exec_en", 32'(exec_en), 32'd0);
      end
      word = 16'($urandom);
      imem_bus.imem_rdata = word;
      imem_bus.imem_ack   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = 16'($urandom);
      chk("exec_en", 32'(exec_en), 32'd1);
      chk("exec_req", 32'(imem_bus.imem_req), 32'd0);
      chk("inst", 32'(inst), 32'(word));
   endtask

   task automatic execute(input logic [2:0] b, input logic [5:0] o, input logic h,
                          input logic zz, input logic nn);
      bit t;
      bs = b; off = o; hlt = h; z = zz; n = nn;
      t = ref_take(b, zz, nn);
      model_pc = ref_next(model_pc, t, o);
      model_bt = t;
      model_instret++;
      @(posedge clk);
      @(negedge clk);
      scramble_decoder();
      chk("next_pc", 32'(pc), 32'(model_pc));
      chk("branch_taken", 32'(branch_taken), 32'(model_bt));
      chk("post_exec_en", 32'(exec_en), 32'd0);
      chk("post_halted", 32'(halted), 32'(h));
      chk("post_req", 32'(imem_bus.imem_req), 32'(!h));
      chk("instret", instret, exp_instret());
   endtask

   task automatic instr(input int waits, input logic [2:0] b, input logic [5:0] o,
                        input logic h, input logic zz, input logic nn);
      logic [15:0] w;
      fetch(waits, w);
      execute(b, o, h, zz, nn);
   endtask

   task automatic resume(input int idle);
      repeat (idle) begin
         @(posedge clk);
         @(negedge clk);
         chk("halt_req", 32'(imem_bus.imem_req), 32'd0);
         chk("halt_pc", 32'(pc), 32'(model_pc));
         chk("halt_halted", 32'(halted), 32'd1);
      end
      run = 1'b1;
      @(posedge clk);
      @(negedge clk);
      run = 1'b0;
      chk("resume_req", 32'(imem_bus.imem_req), 32'd1);
      chk("resume_addr", 32'(imem_bus.imem_addr), 32'(model_pc));
      chk("resume_halted", 32'(halted), 32'd0);
   endtask

   initial begin
      logic [15:0] w;
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = 16'h0000;
      run = 1'b0;
      scramble_decoder();
      #2;
      reset_seq(3);

      // Straight-line code, then an ack stall at pc=5, then HALT at pc=7.
      instr(0, 3'b100, 6'd0, 1'b0, 1'b0, 1'b0);
      instr(0, 3'b100, 6'd0, 1'b0, 1'b0, 1'b0);
      instr(0, 3'b100, 6'd0, 1'b0, 1'b0, 1'b0);
      instr(0, 3'b101, 6'd9, 1'b0, 1'b1, 1'b1);
      instr(0, 3'b110, 6'd9, 1'b0, 1'b1, 1'b1);
      instr(4, 3'b111, 6'd3, 1'b0, 1'b1, 1'b0);
      instr(0, 3'b100, 6'd0, 1'b0, 1'b0, 1'b0);
      instr(0, 3'b100, 6'd0, 1'b1, 1'b0, 1'b0);
      resume(10);

      // Branches around 0x0010.
      instr(0, 3'b000, 6'd7,       1'b0, 1'b1, 1'b0);
      instr(0, 3'b000, 6'b111100,  1'b0, 1'b1, 1'b0);
      instr(0, 3'b000, 6'd2,       1'b0, 1'b1, 1'b0);
      instr(0, 3'b000, 6'b111100,  1'b0, 1'b0, 1'b0);
      instr(0, 3'b001, 6'b111110,  1'b0, 1'b0, 1'b0);
      instr(0, 3'b011, 6'd5,       1'b0, 1'b0, 1'b1);
      instr(0, 3'b100, 6'd5,       1'b0, 1'b1, 1'b1);
      instr(1, 3'b010, 6'b111111,  1'b0, 1'b0, 1'b0);

      // Async reset in the middle of a fetch.
      imem_bus.imem_ack = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_seq(2);

      // Wrap-around at both ends of the address space.
      instr(0, 3'b000, 6'b111110, 1'b0, 1'b1, 1'b0);
      instr(0, 3'b001, 6'd2,      1'b0, 1'b0, 1'b0);
      instr(0, 3'b000, 6'b111100, 1'b0, 1'b1, 1'b0);
      instr(0, 3'b000, 6'd0,      1'b0, 1'b0, 1'b0);

      // Async reset during EXEC must suppress the execute strobe.
      fetch(0, w);
      reset_seq(1);

      for (int k = 0; k < 60; k++) begin
         logic h;
         h = ($urandom_range(0, 7) == 0);
         instr($urandom_range(0, 3), 3'($urandom), 6'($urandom), h, 1'($urandom), 1'($urandom));
         if (h) resume($urandom_range(1, 4));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
